// File: rtl/brew_sequencer.sv
// Step sequencer for the coffee-machine controller: walks NUM_STEPS process steps,
// each dwelling dwell_cfg[k]+1 enabled cycles, with start/abort/freeze control.
module brew_sequencer #(
  parameter int NUM_STEPS = 5,
  parameter int DWELL_W   = 8,
  parameter int STEP_W    = $clog2(NUM_STEPS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         enable,
  input  logic [NUM_STEPS*DWELL_W-1:0] dwell_cfg,
  output logic [STEP_W-1:0]            step,
  output logic                         busy,
  output logic                         step_strobe,
  output logic                         done,
  output logic                         aborted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                strobe_q, strobe_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;

  logic [DWELL_W-1:0]  dwellArr [NUM_STEPS];
  logic [STEP_W-1:0]   stepInc;

  for (genvar k = 0; k < NUM_STEPS; k++) begin : gUnpack
    assign dwellArr[k] = dwell_cfg[k*DWELL_W +: DWELL_W];
  end

  assign stepInc = step_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      step_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // DONE behaves like IDLE for a start request, which gives back-to-back sequences.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        step_d = '0;
        if (start && !abort) begin
          state_d  = RUN;
          cnt_d    = dwellArr[0];
          strobe_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = IDLE;
          step_d    = '0;
          aborted_d = 1'b1;
        end else if (!enable) begin
          state_d = RUN;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (step_q != STEP_W'(NUM_STEPS - 1)) begin
          step_d   = stepInc;
          cnt_d    = dwellArr[stepInc];
          strobe_d = 1'b1;
        end else begin
          state_d = DONE;
          step_d  = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  assign step        = step_q;
  assign busy        = busy_q;
  assign step_strobe = strobe_q;
  assign done        = done_q;
  assign aborted     = aborted_q;

endmodule

// File: tb/tb_brew_sequencer.sv
// Directed bench for brew_sequencer (NUM_STEPS=5, DWELL_W=4) with hand-computed
// expectations checked by immediate assertions.
module tb_brew_sequencer;

  localparam int NUM_STEPS = 5;
  localparam int DWELL_W   = 4;
  localparam int STEP_W    = 3;

  // Step 0 sits in the low nibble: dwell = {2,0,3,1,0}
  localparam logic [19:0] DWELL_BASIC = {4'd0, 4'd1, 4'd3, 4'd0, 4'd2};
  localparam logic [19:0] DWELL_ZERO  = 20'h0;

  logic                         clk;
  logic                         rst_n;
  logic                         start;
  logic                         abort;
  logic                         enable;
  logic [NUM_STEPS*DWELL_W-1:0] dwell_cfg;
  logic [STEP_W-1:0]            step;
  logic                         busy;
  logic                         step_strobe;
  logic                         done;
  logic                         aborted;

  int compared;
  int mismatched;
  int strobes;
  int edgeNum;

  logic [2:0] expSteps [11] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4};

  brew_sequencer #(
    .NUM_STEPS(NUM_STEPS),
    .DWELL_W  (DWELL_W),
    .STEP_W   (STEP_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .enable     (enable),
    .dwell_cfg  (dwell_cfg),
    .step       (step),
    .busy       (busy),
    .step_strobe(step_strobe),
    .done       (done),
    .aborted    (aborted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic s, input logic a, input logic e);
    start  = s;
    abort  = a;
    enable = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    dwell_cfg  = DWELL_BASIC;
    applyStimulus(1'b0, 1'b0, 1'b1);
    #12;
    checkOutput("rstStep", 32'(step), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstStrobe", 32'(step_strobe), 0);
    checkOutput("rstDone", 32'(done), 0);
    checkOutput("rstAborted", 32'(aborted), 0);
    rst_n = 1'b1;
    tick();

    // Basic run
    $display("[TB] basic run");
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    strobes = 0;
    for (int i = 0; i < 11; i++) begin
      checkOutput($sformatf("basicStep%0d", i), 32'(step), 32'(expSteps[i]));
      checkOutput($sformatf("basicBusy%0d", i), 32'(busy), 1);
      checkOutput($sformatf("basicDone%0d", i), 32'(done), 0);
      if (step_strobe) strobes++;
      if (i < 10) tick();
    end
    checkOutput("basicStrobeCount", 32'(strobes), 5);
    tick();
    checkOutput("basicDoneE11", 32'(done), 1);
    checkOutput("basicBusyE11", 32'(busy), 0);
    checkOutput("basicStepE11", 32'(step), 0);
    tick();
    checkOutput("basicDonePulse", 32'(done), 0);

    // Stall three cycles in step 2
    $display("[TB] stall");
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    checkOutput("stallEntryStep", 32'(step), 2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("stallStep%0d", i), 32'(step), 2);
      checkOutput($sformatf("stallStrobe%0d", i), 32'(step_strobe), 0);
      checkOutput($sformatf("stallBusy%0d", i), 32'(busy), 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    edgeNum = 7;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      edgeNum++;
    end
    checkOutput("stallDoneSeen", 32'(done), 1);
    checkOutput("stallDoneEdge", 32'(edgeNum), 14);
    tick();

    // Abort during step 3
    $display("[TB] abort");
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (8) tick();
    checkOutput("abortPreStep", 32'(step), 3);
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("abortAborted", 32'(aborted), 1);
    checkOutput("abortBusy", 32'(busy), 0);
    checkOutput("abortStep", 32'(step), 0);
    checkOutput("abortNoDone", 32'(done), 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("abortPulse", 32'(aborted), 0);
    checkOutput("abortNoDoneLater", 32'(done), 0);
    checkOutput("abortIdleBusy", 32'(busy), 0);

    // start and abort together in IDLE
    $display("[TB] start/abort race");
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("raceBusy", 32'(busy), 0);
    checkOutput("raceStrobe", 32'(step_strobe), 0);
    checkOutput("raceAborted", 32'(aborted), 0);
    checkOutput("raceDone", 32'(done), 0);

    // start held through DONE
    $display("[TB] back-to-back");
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    repeat (11) tick();
    checkOutput("b2bDone", 32'(done), 1);
    checkOutput("b2bBusyLow", 32'(busy), 0);
    tick();
    checkOutput("b2bStrobe", 32'(step_strobe), 1);
    checkOutput("b2bBusy", 32'(busy), 1);
    checkOutput("b2bStep", 32'(step), 0);
    checkOutput("b2bDoneCleared", 32'(done), 0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("b2bAbort", 32'(aborted), 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();

    // All-zero dwells
    $display("[TB] zero dwells");
    dwell_cfg = DWELL_ZERO;
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("zeroStep%0d", i), 32'(step), 32'(i));
      checkOutput($sformatf("zeroBusy%0d", i), 32'(busy), 1);
      checkOutput($sformatf("zeroStrobe%0d", i), 32'(step_strobe), 1);
      tick();
    end
    checkOutput("zeroDone", 32'(done), 1);
    checkOutput("zeroBusyEnd", 32'(busy), 0);
    tick();

    // Asynchronous reset mid-step 2
    $display("[TB] async reset");
    dwell_cfg = DWELL_BASIC;
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    checkOutput("arstPreStep", 32'(step), 2);
    checkOutput("arstPreStrobe", 32'(step_strobe), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arstStep", 32'(step), 0);
    checkOutput("arstBusy", 32'(busy), 0);
    checkOutput("arstStrobe", 32'(step_strobe), 0);
    checkOutput("arstDone", 32'(done), 0);
    checkOutput("arstAborted", 32'(aborted), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("arstIdleBusy%0d", i), 32'(busy), 0);
      checkOutput($sformatf("arstIdleStrobe%0d", i), 32'(step_strobe), 0);
      checkOutput($sformatf("arstIdleStep%0d", i), 32'(step), 0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("arstRestartBusy", 32'(busy), 1);
    checkOutput("arstRestartStrobe", 32'(step_strobe), 1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("arstCleanupAbort", 32'(aborted), 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
